// File: rtl/cordic_ctrl_pkg.sv
// Shared constants and the in-flight tag type for the CORDIC arbiter.
package cordic_ctrl_pkg;

  localparam int FP32_W         = 32;
  localparam int CORDIC_LATENCY = 16;
  // Two id bits cover the largest supported requester count (4).
  localparam int TAG_ID_W       = 2;
  // Wide enough to count 0..CORDIC_LATENCY.
  localparam int INFLIGHT_W     = 5;

  typedef struct packed {
    logic                v;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/cordic_arbiter_if.sv
// Requester-side request/response channels of the CORDIC arbiter.
interface cordic_arbiter_if #(
  parameter int NUM_REQ = 2
);
  import cordic_ctrl_pkg::*;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [FP32_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ-1:0]        rsp_ready;
  logic [FP32_W-1:0]         rsp_data;

  // Requesters issue angles and consume results.
  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  // The arbiter accepts angles and returns results.
  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one grant per enabled cycle, search starts at the
// pointer, pointer moves just past the winner.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 2
) (
  input  logic               clock,
  input  logic               aclr_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    gnt_idx_o,
  output logic               gnt_vld_o
);

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] idx;
  logic            found;

  // Find the first active request at or after the pointer, wrapping around.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int c = 0; c < NUM_REQ; c++) begin
        if (!found && req_i[c] && (c == (int'(ptr_q) + k) % NUM_REQ)) begin
          found = 1'b1;
          idx   = ID_W'(c);
        end
      end
    end
  end

  // Qualify the winner with the enable and form the one-hot grant.
  always_comb begin
    gnt_vld_o = found & en_i;
    gnt_idx_o = idx;
    gnt_o     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt_o[i] = gnt_vld_o && (idx == ID_W'(i));
    end
    ptr_d = gnt_vld_o ? ID_W'((int'(idx) + 1) % NUM_REQ) : ptr_q;
  end

  // Pointer register.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/cordic_arbiter.sv
// Shares one CORDIC pipeline between NUM_REQ requesters. A {valid,id} tag
// shifts alongside the pipeline so each result is steered back to its
// issuer; a result its owner cannot take freezes the whole pipeline.
module cordic_arbiter
  import cordic_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int LATENCY = CORDIC_LATENCY,
  parameter int ID_W    = TAG_ID_W
) (
  input  logic                  clock,
  input  logic                  aclr_n,
  input  logic                  flush,
  cordic_arbiter_if.slave       bus,
  output logic [FP32_W-1:0]     cordic_dataa,
  output logic                  cordic_clk_en,
  output logic                  cordic_aclr,
  input  logic [FP32_W-1:0]     cordic_result,
  output logic                  busy,
  output logic [INFLIGHT_W-1:0] in_flight
);

  tag_t                  tag_q [LATENCY];
  tag_t                  tag_d [LATENCY];
  logic                  aclr_q, aclr_d;
  logic [INFLIGHT_W-1:0] in_flight_q, in_flight_d;

  logic                  head_v;
  logic [TAG_ID_W-1:0]   head_id;
  logic                  xfer;
  logic                  stall;
  logic                  arb_en;
  logic [NUM_REQ-1:0]    gnt;
  logic [ID_W-1:0]       gnt_idx;
  logic                  gnt_vld;

  assign head_v  = tag_q[LATENCY-1].v;
  assign head_id = tag_q[LATENCY-1].id;

  // Offer the head result only to the requester that issued it.
  always_comb begin
    bus.rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.rsp_valid[i] = head_v && (head_id == TAG_ID_W'(i));
    end
  end

  assign bus.rsp_data  = cordic_result;
  assign xfer          = |(bus.rsp_valid & bus.rsp_ready);
  assign stall         = head_v & ~xfer;
  // While the pipeline is being cleared it must not advance either.
  assign cordic_clk_en = ~stall & ~aclr_q;
  assign cordic_aclr   = aclr_q;
  // No new work enters in a flush cycle; it would be discarded anyway.
  assign arb_en        = cordic_clk_en & ~flush;
  assign bus.req_ready = gnt;
  assign in_flight     = in_flight_q;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .clock     (clock),
    .aclr_n    (aclr_n),
    .req_i     (bus.req_valid),
    .en_i      (arb_en),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  // Steer the granted angle into the pipeline; bubbles carry zero.
  always_comb begin
    cordic_dataa = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        cordic_dataa = bus.req_data[FP32_W*i +: FP32_W];
      end
    end
  end

  // Tag pipe moves in lockstep with the datapath; flush drops every tag.
  always_comb begin
    for (int k = 0; k < LATENCY; k++) begin
      tag_d[k] = tag_q[k];
    end
    if (flush) begin
      for (int k = 0; k < LATENCY; k++) begin
        tag_d[k] = '0;
      end
    end else if (cordic_clk_en) begin
      tag_d[0].v  = gnt_vld;
      tag_d[0].id = TAG_ID_W'(gnt_idx);
      for (int k = 1; k < LATENCY; k++) begin
        tag_d[k] = tag_q[k-1];
      end
    end
  end

  // Occupancy count, pipeline-clear request and busy flag.
  always_comb begin
    aclr_d = flush;
    if (flush) begin
      in_flight_d = '0;
    end else begin
      in_flight_d = in_flight_q + INFLIGHT_W'(gnt_vld) - INFLIGHT_W'(xfer);
    end
    busy = 1'b0;
    for (int k = 0; k < LATENCY; k++) begin
      busy = busy | tag_q[k].v;
    end
  end

  // State registers; the clear request is held for the first clock after reset.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      aclr_q      <= 1'b1;
      in_flight_q <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      aclr_q      <= aclr_d;
      in_flight_q <= in_flight_d;
      for (int k = 0; k < LATENCY; k++) begin
        tag_q[k] <= tag_d[k];
      end
    end
  end

endmodule

// File: tb/tb_cordic_arbiter.sv
// Randomised scoreboard bench for cordic_arbiter with a stand-in pipeline.
module tb_cordic_arbiter;
  import cordic_ctrl_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int LATENCY = 16;
  localparam int ID_W    = 2;

  logic        clock = 1'b0;
  logic        aclr_n = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] cordic_dataa;
  logic [31:0] cordic_result;
  logic        cordic_clk_en;
  logic        cordic_aclr;
  logic        busy;
  logic [4:0]  in_flight;

  cordic_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  cordic_arbiter #(
    .NUM_REQ (NUM_REQ),
    .LATENCY (LATENCY),
    .ID_W    (ID_W)
  ) dut (
    .clock         (clock),
    .aclr_n        (aclr_n),
    .flush         (flush),
    .bus           (bus),
    .cordic_dataa  (cordic_dataa),
    .cordic_clk_en (cordic_clk_en),
    .cordic_aclr   (cordic_aclr),
    .cordic_result (cordic_result),
    .busy          (busy),
    .in_flight     (in_flight)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Known cosines for the directed angles; other angles get an arbitrary
  // but deterministic function so routing errors still show up.
  function automatic logic [31:0] cos_ref(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h3F80_0000;
      32'h3F80_0000: return 32'h3F0A_5140;
      32'h3F00_0000: return 32'h3F60_A911;
      default:       return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
    endcase
  endfunction

  // Stand-in CORDIC pipeline: LATENCY clk_en-qualified stages, sync clear.
  logic [31:0] pipe_q [LATENCY];
  always @(posedge clock) begin
    if (cordic_aclr) begin
      for (int k = 0; k < LATENCY; k++) pipe_q[k] <= '0;
    end else if (cordic_clk_en) begin
      pipe_q[0] <= cordic_dataa;
      for (int k = 1; k < LATENCY; k++) pipe_q[k] <= pipe_q[k-1];
    end
  end
  assign cordic_result = cos_ref(pipe_q[LATENCY-1]);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard of outstanding operations, oldest first.
  typedef struct {
    int          id;
    logic [31:0] data;
    longint      t0;
  } exp_t;
  exp_t sb[$];

  logic [31:0]        pend [NUM_REQ][$];
  logic [NUM_REQ-1:0] acc_mask = '0;
  logic [NUM_REQ-1:0] rdy_lo = '0;
  int                 gap_pct = 100;
  int                 rdy_pct = 100;
  int                 stall_cnt = 0;
  int                 max_if = 0;

  // Driver: hold each request until accepted, randomise starts and readiness.
  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.rsp_ready = '0;
    forever begin
      @(posedge clock);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc_mask[i] && pend[i].size() > 0) pend[i].delete(0);
        if (!(bus.req_valid[i] && !acc_mask[i]))
          bus.req_valid[i] = (pend[i].size() > 0) && (int'($urandom_range(99)) < gap_pct);
        if (pend[i].size() > 0) bus.req_data[32*i +: 32] = pend[i][0];
        bus.rsp_ready[i] = !rdy_lo[i] && (int'($urandom_range(99)) < rdy_pct);
      end
    end
  end

  // Monitor: reference model of arbitration, ordering, latency and flush.
  initial begin
    int                 rr_m;
    logic               exp_aclr;
    logic               exp_ce;
    longint             active_cnt;
    logic [NUM_REQ-1:0] erv;
    logic [NUM_REQ-1:0] err;
    int                 c;
    int                 gi;
    exp_t               e;
    rr_m = 0;
    exp_aclr = 1'b1;
    active_cnt = 0;
    forever begin
      @(negedge clock);
      if (!aclr_n) begin
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_clk_en", 32'(cordic_clk_en), 32'd0);
        chk("rst_aclr", 32'(cordic_aclr), 32'd1);
        chk("rst_in_flight", 32'(in_flight), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        sb.delete();
        rr_m = 0;
        exp_aclr = 1'b1;
        acc_mask = '0;
      end else begin
        chk("aclr", 32'(cordic_aclr), 32'(exp_aclr));
        chk("in_flight", 32'(in_flight), 32'(sb.size()));
        chk("busy", 32'(busy), 32'(sb.size() != 0));
        if (int'(in_flight) > max_if) max_if = int'(in_flight);
        erv = '0;
        if (sb.size() > 0 && active_cnt - sb[0].t0 == longint'(LATENCY)) erv[sb[0].id] = 1'b1;
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(erv));
        if (|erv) chk("rsp_data", bus.rsp_data, sb[0].data);
        exp_ce = !exp_aclr && !(|(erv & ~bus.rsp_ready));
        chk("clk_en", 32'(cordic_clk_en), 32'(exp_ce));
        err = '0;
        gi = -1;
        if (exp_ce && !flush) begin
          for (int k = 0; k < NUM_REQ; k++) begin
            c = (rr_m + k) % NUM_REQ;
            if (gi < 0 && bus.req_valid[c]) begin
              gi = c;
              err[c] = 1'b1;
            end
          end
        end
        chk("req_ready", 32'(bus.req_ready), 32'(err));
        acc_mask = bus.req_valid & bus.req_ready;
        if (|(erv & bus.rsp_ready)) void'(sb.pop_front());
        if (gi >= 0) begin
          e.id = gi;
          e.data = cos_ref(bus.req_data[32*gi +: 32]);
          e.t0 = active_cnt;
          sb.push_back(e);
          rr_m = (gi + 1) % NUM_REQ;
        end
        if (flush) sb.delete();
        if (exp_ce) active_cnt++;
        if (!cordic_clk_en) stall_cnt++;
        exp_aclr = flush;
      end
    end
  end

  function automatic bit idle();
    for (int i = 0; i < NUM_REQ; i++) if (pend[i].size() != 0) return 1'b0;
    return sb.size() == 0;
  endfunction

  task automatic wait_drain(input string nm, input int budget);
    int n;
    n = 0;
    while (n < budget && !idle()) begin
      @(posedge clock);
      #2;
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s: not drained after %0d cycles (budget %0d)", nm, n, budget);
    end
  endtask

  task automatic wait_inflight(input string nm, input int target);
    int n;
    n = 0;
    @(negedge clock);
    while (n < 200 && int'(in_flight) != target) begin
      @(negedge clock);
      n++;
    end
    chk(nm, 32'(in_flight), 32'(target));
  endtask

  initial begin
    int n;
    int t_start;
    int stalls;
    int no_gnt;
    repeat (3) @(posedge clock);
    #1 aclr_n = 1'b1;

    // Single op: cos(0) = 1.0 after LATENCY cycles.
    pend[0].push_back(32'h0000_0000);
    wait_drain("single_op", 200);

    // Two requesters held valid: grants and results alternate.
    for (int j = 0; j < 4; j++) begin
      pend[0].push_back(32'h3F80_0000);
      pend[1].push_back(32'h3F00_0000);
    end
    wait_drain("alternate", 300);

    // Requester 1 refuses its result for 5 cycles at the head.
    rdy_lo = 2'b10;
    for (int j = 0; j < 3; j++) begin
      pend[0].push_back($urandom);
      pend[1].push_back($urandom);
    end
    n = 0;
    @(negedge clock);
    while (n < 200 && !bus.rsp_valid[1]) begin
      @(negedge clock);
      n++;
    end
    chk("stall_head_reached", 32'(bus.rsp_valid[1]), 32'd1);
    stalls = 0;
    no_gnt = 0;
    for (int j = 0; j < 5; j++) begin
      if (j > 0) @(negedge clock);
      if (!cordic_clk_en) stalls++;
      if (bus.req_ready == '0) no_gnt++;
    end
    chk("stall_cycles", 32'(stalls), 32'd5);
    chk("stall_no_grant", 32'(no_gnt), 32'd5);
    @(posedge clock);
    rdy_lo = '0;
    wait_drain("stall_release", 300);

    // Flush with about ten ops in flight, then new ops complete normally.
    for (int j = 0; j < 40; j++) pend[0].push_back($urandom);
    wait_inflight("flush_fill", 9);
    @(posedge clock);
    #1 flush = 1'b1;
    @(posedge clock);
    #1 flush = 1'b0;
    @(negedge clock);
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_in_flight", 32'(in_flight), 32'd0);
    chk("flush_aclr", 32'(cordic_aclr), 32'd1);
    wait_drain("after_flush", 600);

    // Asynchronous reset mid-stream with ops in flight.
    for (int j = 0; j < 30; j++) pend[1].push_back($urandom);
    wait_inflight("reset_fill", 6);
    @(posedge clock);
    #3 aclr_n = 1'b0;
    #1;
    chk("async_in_flight", 32'(in_flight), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("async_req_ready", 32'(bus.req_ready), 32'd0);
    chk("async_clk_en", 32'(cordic_clk_en), 32'd0);
    chk("async_aclr", 32'(cordic_aclr), 32'd1);
    repeat (2) @(posedge clock);
    #1 aclr_n = 1'b1;
    wait_drain("after_reset", 600);

    // Sustained 1 op/cycle with every responder ready.
    stall_cnt = 0;
    max_if = 0;
    t_start = cyc;
    for (int j = 0; j < 50; j++) begin
      pend[0].push_back($urandom);
      pend[1].push_back($urandom);
    end
    wait_drain("sustained", 400);
    chk("sustained_stalls", 32'(stall_cnt), 32'd0);
    chk("sustained_max_in_flight", 32'(max_if), 32'(LATENCY));
    checks++;
    if (cyc - t_start > 100 + LATENCY + 6) begin
      errors++;
      $display("FAIL sustained_rate: took %0d cycles, limit %0d", cyc - t_start, 100 + LATENCY + 6);
    end

    // Random traffic with random request gaps and response backpressure.
    for (int r = 0; r < 4; r++) begin
      gap_pct = int'($urandom_range(100, 30));
      rdy_pct = int'($urandom_range(100, 40));
      for (int i = 0; i < NUM_REQ; i++) begin
        n = int'($urandom_range(20, 5));
        for (int j = 0; j < n; j++) pend[i].push_back($urandom);
      end
      wait_drain("random", 3000);
    end
    gap_pct = 100;
    rdy_pct = 100;

    repeat (3) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #600000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cordic_arbiter.md
Name: cordic_arbiter

Overview:
- Shares one cordic_pipeline instance between NUM_REQ requesters, each with valid/ready request and response channels.
- Drives the pipeline's dataa, clk_en and aclr.
- Tracks each in-flight operation with a valid+id tag shift register matched to pipeline latency, and routes each result back to its issuer.
- Applies backpressure by freezing the whole pipeline through clk_en. Sits between the custom-instruction/bus front end and the CORDIC datapath.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- LATENCY, 16, clk_en-qualified cycles from dataa sample to valid result.
- ID_W, 2, tag id width; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clock  in  1  system clock
- aclr_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous pulse; discards all in-flight operations
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester request accepted
- req_data  in  32*NUM_REQ  per-requester FP32 angle (requester i at bits [32i+31:32i])
- rsp_valid  out  NUM_REQ  per-requester result valid
- rsp_ready  in  NUM_REQ  per-requester result consumed
- rsp_data  out  32  FP32 cosine, shared bus, meaningful only with rsp_valid
- cordic_dataa  out  32  to pipeline dataa
- cordic_clk_en  out  1  to pipeline clk_en
- cordic_aclr  out  1  to pipeline aclr (synchronous, active-high)
- cordic_result  in  32  from pipeline result
- busy  out  1  any tag valid
- in_flight  out  5  count of valid tags (0..LATENCY)

Behaviour:
- Reset (aclr_n=0, asynchronous): tags cleared, rr pointer=0, in_flight=0, busy=0, req_ready=0, rsp_valid=0, cordic_clk_en=0, cordic_aclr=1.
  - cordic_aclr stays 1 for the first clock after aclr_n deasserts, so pipeline registers clear synchronously, then goes 0.
- Tag pipe: LATENCY entries {v, id}. Entry 0 loads with the cycle's issue; entry LATENCY-1 aligns with cordic_result.
  - Shifts only when cordic_clk_en=1.
- head_v = tag[LATENCY-1].v; head_id = tag[LATENCY-1].id.
- stall = head_v & ~rsp_ready[head_id].
- cordic_clk_en = ~stall & ~cordic_aclr. The pipeline advances every unstalled cycle, with bubbles when there is no issue.
- rsp_valid[i] = head_v & (head_id==i). rsp_data = cordic_result (combinational). A transfer completes when rsp_valid[i] & rsp_ready[i].
- Arbitration: round-robin over req_valid starting at rr pointer.
  - Grant only when cordic_clk_en=1 and flush=0.
  - req_ready[g]=1 for the granted index only. cordic_dataa = req_data[g]; tag[0] = {1, g}.
  - The rr pointer moves to g+1 mod NUM_REQ after each grant.
  - With no grant, tag[0].v=0 and cordic_dataa=0.
- req_ready is combinational from req_valid, rr pointer and stall. A requester must hold req_valid/req_data until accepted.
- in_flight: +1 on grant, −1 on response transfer; both together leave it unchanged. Never exceeds LATENCY.
- Throughput: 1 op/cycle sustained when all responders are ready. Latency from grant to rsp_valid = LATENCY cycles, excluding stall cycles.
- Stall: the whole pipe freezes and no grants are issued. Results behind the head are held and not lost.
- Flush: all tag v cleared, in_flight=0, rsp_valid=0 next cycle, cordic_aclr=1 for that one cycle, no grant in the flush cycle. Flush overrides stall.
- Simultaneous response transfer and grant in the same cycle is legal; counts net out.
- A requester may have several ops in flight. Results return in issue order.

Decomposition:
- Package cordic_ctrl_pkg: LATENCY constant, tag struct {v, id}, FP32 width constant.
- One sub-module: rr_arbiter (NUM_REQ requests, enable, grant one-hot + index, pointer update). Instantiated once.
- cordic_pipeline is instantiated by the parent, not inside this block.

Test Plan:
- Single op, requester 0, angle 0x00000000, rsp_ready=1 → rsp_valid[0] exactly 16 cycles after accept; rsp_data ≈ 0x3F800000 (1.0 within 2^-16); in_flight 1 → 0.
- Both requesters hold valid continuously with angles 0x3F800000 (1.0) and 0x3F000000 (0.5) → grants alternate 0,1,0,1; responses alternate with data ≈ 0.5403 and ≈ 0.8776.
- Requester 1 holds rsp_ready=0 for 5 cycles while its result is at the head → cordic_clk_en=0 for 5 cycles; no grants; subsequent results intact and in order; no op lost.
- 10 ops in flight, flush pulse → next cycle busy=0, in_flight=0, cordic_aclr=1 for one cycle; no rsp_valid for the flushed ops; a new op after flush returns correctly 16 cycles later.
- aclr_n asserted mid-stream with 7 ops in flight → outputs immediately at reset values; after release, cordic_aclr high one cycle then 0; the first new op returns in 16 cycles.
- Grant and response transfer in the same cycle at in_flight=16 → in_flight stays 16; sustained 1 op/cycle for 100 ops with zero stall cycles.
